logic_issue: RTL and testbench

Issue/writeback sequencer that sits directly upstream of the 8-bit AND/OR logical unit in the FPGA CPU datapath. It accepts one instruction per handshake and reads two operands from a 4 x 8-bit register file. It drives the unit's `A`, `B` and `OP` inputs from registers, captures the unit's `Y` result and writes it back to the destination register. The register file is also loadable and readable from outside for setup and debug.

---
 rtl/logic_pkg.sv | 23 ++
 rtl/logic_regfile.sv | 39 +++
 rtl/logic_issue.sv | 149 ++++++++++++++
 tb/tb_logic_issue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the logic_issue sequencer: FSM states, instruction
// field positions and datapath defaults.
package logic_pkg;

    localparam int W_DEF     = 8;
    localparam int NREGS_DEF = 4;

    // Instruction field positions within the 8-bit INSTR word
    localparam int OP_BIT = 7;
    localparam int RD_HI  = 6;
    localparam int RD_LO  = 5;
    localparam int RA_HI  = 4;
    localparam int RA_LO  = 3;
    localparam int RB_HI  = 2;
    localparam int RB_LO  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/logic_regfile.sv
// Small register file: one synchronous write port, three combinational
// read ports (two operand reads plus one debug read).
module logic_regfile
    import logic_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int W     = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [1:0]   ra_addr,
    input  logic [1:0]   rb_addr,
    input  logic [1:0]   dbg_addr,
    output logic [W-1:0] ra_data,
    output logic [W-1:0] rb_data,
    output logic [W-1:0] dbg_data
);

    logic [W-1:0] regs_r [NREGS];

    // Storage update: clear on reset, otherwise a single write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {W{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign ra_data  = regs_r[ra_addr];
    assign rb_data  = regs_r[rb_addr];
    assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/logic_issue.sv
// Issue/writeback sequencer feeding an external AND/OR logical unit.
// One instruction every three cycles: IDLE (accept, read operands),
// EXEC (unit result settles, captured), WB (result written to RD).
module logic_issue
    import logic_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int W     = W_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [7:0]   INSTR,
    input  logic         LD_EN,
    input  logic [1:0]   LD_ADDR,
    input  logic [W-1:0] LD_DATA,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic         OP,
    input  logic [W-1:0] Y,
    output logic [W-1:0] RESULT,
    output logic         DONE,
    input  logic [1:0]   RD_ADDR,
    output logic [W-1:0] RD_DATA
);

    state_t       state_r;
    state_t       state_nxt_s;
    logic         accept_s;
    logic         ld_ok_s;
    logic         wb_s;
    logic         we_s;
    logic [1:0]   waddr_s;
    logic [W-1:0] wdata_s;
    logic [W-1:0] ra_data_s;
    logic [W-1:0] rb_data_s;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic         op_r;
    logic [1:0]   rd_r;
    logic [W-1:0] result_r;
    logic         unused_s;

    // Bit 0 of the instruction is reserved and carries no meaning
    assign unused_s = INSTR[0];

    logic_regfile #(
        .NREGS (NREGS),
        .W     (W)
    ) u_regfile (
        .clk      (CLK),
        .rst      (RST),
        .we       (we_s),
        .waddr    (waddr_s),
        .wdata    (wdata_s),
        .ra_addr  (INSTR[RA_HI:RA_LO]),
        .rb_addr  (INSTR[RB_HI:RB_LO]),
        .dbg_addr (RD_ADDR),
        .ra_data  (ra_data_s),
        .rb_data  (rb_data_s),
        .dbg_data (RD_DATA)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus accept/load/writeback qualifiers
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        ld_ok_s     = 1'b0;
        wb_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ld_ok_s = LD_EN;
                if (IN_VALID) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_WB;
            end
            ST_WB: begin
                wb_s        = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Register-file write port: writeback (WB) and load (IDLE) never overlap
    always_comb begin
        we_s    = 1'b0;
        waddr_s = LD_ADDR;
        wdata_s = LD_DATA;
        if (wb_s) begin
            we_s    = 1'b1;
            waddr_s = rd_r;
            wdata_s = result_r;
        end else if (ld_ok_s) begin
            we_s    = 1'b1;
            waddr_s = LD_ADDR;
            wdata_s = LD_DATA;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Operand/opcode capture on accept and result capture in EXEC
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r      <= {W{1'b0}};
            b_r      <= {W{1'b0}};
            op_r     <= 1'b0;
            rd_r     <= 2'd0;
            result_r <= {W{1'b0}};
        end else begin
            if (accept_s) begin
                a_r  <= ra_data_s;
                b_r  <= rb_data_s;
                op_r <= INSTR[OP_BIT];
                rd_r <= INSTR[RD_HI:RD_LO];
            end
            if (state_r == ST_EXEC) begin
                result_r <= Y;
            end
        end
    end

    assign A        = a_r;
    assign B        = b_r;
    assign OP       = op_r;
    assign RESULT   = result_r;
    assign IN_READY = (state_r == ST_IDLE) && !RST;
    assign DONE     = (state_r == ST_WB) && !RST;

endmodule

// File: tb/tb_logic_issue.sv
// Scoreboard bench for logic_issue: stimulus pushes expected operands and
// result per accepted instruction; a monitor pops and compares on DONE.
module tb_logic_issue;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] INSTR;
    logic       LD_EN;
    logic [1:0] LD_ADDR;
    logic [7:0] LD_DATA;
    logic [7:0] A;
    logic [7:0] B;
    logic       OP;
    logic [7:0] Y;
    logic [7:0] RESULT;
    logic       DONE;
    logic [1:0] RD_ADDR;
    logic [7:0] RD_DATA;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    logic_issue #(.NREGS(4), .W(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .INSTR    (INSTR),
        .LD_EN    (LD_EN),
        .LD_ADDR  (LD_ADDR),
        .LD_DATA  (LD_DATA),
        .A        (A),
        .B        (B),
        .OP       (OP),
        .Y        (Y),
        .RESULT   (RESULT),
        .DONE     (DONE),
        .RD_ADDR  (RD_ADDR),
        .RD_DATA  (RD_DATA)
    );

    // The logical unit that sits beside the sequencer
    assign Y = OP ? (A & B) : (A | B);

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic op, input logic [7:0] res);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.res = res;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        LD_EN = 1'b1; LD_ADDR = addr; LD_DATA = data;
        tick();
        LD_EN = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [1:0] addr, input logic [7:0] exp);
        RD_ADDR = addr;
        #1;
        check(name, RD_DATA, exp);
    endtask

    // Offer one instruction; returns one cycle after the accept edge (EXEC)
    task automatic issue(input logic [7:0] instr, input bit push, input exp_t e);
        int n;
        n = 0;
        INSTR = instr; IN_VALID = 1'b1;
        while (IN_READY !== 1'b1 && n < 10) begin
            tick(); n++;
        end
        if (IN_READY !== 1'b1) begin
            total++; bad++;
            $display("FAIL accept_timeout: instr %0h not accepted", instr);
        end else begin
            if (push) sb_q.push_back(e);
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (DONE === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got DONE=1 expected no pulse");
            end else begin
                e = sb_q.pop_front();
                check("wb_result", RESULT, e.res);
                check("wb_operands", {A, B, OP}, {e.a, e.b, e.op});
            end
        end
    end

    initial begin
        logic [7:0] prog [3];
        exp_t       pexp [3];
        int         acc  [3];
        int         n;

        RST = 1'b1; IN_VALID = 1'b0; INSTR = 8'h00; LD_EN = 1'b0;
        LD_ADDR = 2'd0; LD_DATA = 8'h00; RD_ADDR = 2'd0;
        tick(); tick();

        // Reset state
        check("ready_in_rst", IN_READY, 1'b0);
        check("done_in_rst", DONE, 1'b0);
        check("outs_rst", {A, B, OP, RESULT}, 25'h0);
        for (int i = 0; i < 4; i++) check_reg("reg_rst", 2'(i), 8'h00);
        RST = 1'b0;
        #1;
        check("ready_after_rst", IN_READY, 1'b1);
        check("done_after_rst", DONE, 1'b0);

        // AND R0,R1 -> R2
        load(2'd0, 8'hF0);
        load(2'd1, 8'h3C);
        issue(8'hC2, 1'b1, mk(8'hF0, 8'h3C, 1'b1, 8'h30));
        check("exec_operands", {A, B, OP}, {8'hF0, 8'h3C, 1'b1});
        check("exec_no_done", DONE, 1'b0);
        tick();
        check("wb_done", DONE, 1'b1);
        tick();
        check("ready_again", IN_READY, 1'b1);
        check_reg("and_r2", 2'd2, 8'h30);

        // OR R0,R1 -> R3, then same with reserved bit set
        issue(8'h62, 1'b1, mk(8'hF0, 8'h3C, 1'b0, 8'hFC));
        tick(); tick();
        check_reg("or_r3", 2'd3, 8'hFC);
        load(2'd3, 8'h00);
        check_reg("r3_cleared", 2'd3, 8'h00);
        issue(8'h63, 1'b1, mk(8'hF0, 8'h3C, 1'b0, 8'hFC));
        tick(); tick();
        check_reg("or_r3_rsvd", 2'd3, 8'hFC);

        // Back-to-back with IN_VALID held; each reads the previous destination
        prog[0] = 8'hC6; pexp[0] = mk(8'hF0, 8'hFC, 1'b1, 8'hF0);
        prog[1] = 8'h32; pexp[1] = mk(8'hF0, 8'h3C, 1'b0, 8'hFC);
        prog[2] = 8'h8E; pexp[2] = mk(8'hFC, 8'hFC, 1'b1, 8'hFC);
        IN_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0;
            INSTR = prog[k];
            n = 0;
            while (IN_READY !== 1'b1 && n < 10) begin
                tick(); n++;
            end
            if (IN_READY !== 1'b1) begin
                total++; bad++;
                $display("FAIL b2b_accept_timeout: instr %0h", prog[k]);
            end else begin
                sb_q.push_back(pexp[k]);
                acc[k] = cyc;
                tick();
            end
        end
        IN_VALID = 1'b0;
        tick(); tick();
        check("b2b_gap01", acc[1] - acc[0], 3);
        check("b2b_gap12", acc[2] - acc[1], 3);
        check_reg("b2b_r2", 2'd2, 8'hF0);
        check_reg("b2b_r1", 2'd1, 8'hFC);
        check_reg("b2b_r0", 2'd0, 8'hFC);

        // Load during EXEC is ignored
        load(2'd0, 8'hF0);
        load(2'd1, 8'hFF);
        issue(8'hC2, 1'b1, mk(8'hF0, 8'hFF, 1'b1, 8'hF0));
        LD_EN = 1'b1; LD_ADDR = 2'd0; LD_DATA = 8'hAA;
        tick();
        LD_EN = 1'b0;
        tick();
        check_reg("ld_exec_ignored", 2'd0, 8'hF0);
        check_reg("ld_exec_r2", 2'd2, 8'hF0);

        // Load and accept in the same cycle: old R0 used, load still lands
        LD_EN = 1'b1; LD_ADDR = 2'd0; LD_DATA = 8'h55;
        issue(8'hE2, 1'b1, mk(8'hF0, 8'hFF, 1'b1, 8'hF0));
        LD_EN = 1'b0;
        check_reg("ld_acc_r0", 2'd0, 8'h55);
        tick(); tick();
        check_reg("ld_acc_r3", 2'd3, 8'hF0);

        // Reset during EXEC aborts the instruction
        issue(8'h22, 1'b0, mk(8'h00, 8'h00, 1'b0, 8'h00));
        RST = 1'b1;
        #1;
        check("ready_rst_exec", IN_READY, 1'b0);
        tick();
        check("outs_after_abort", {A, B, OP, RESULT, DONE}, 26'h0);
        check_reg("abort_no_wb", 2'd1, 8'h00);
        RST = 1'b0;
        #1;
        check("idle_after_abort", IN_READY, 1'b1);
        tick(); tick(); tick();
        check("done_count", done_cnt, 8);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
